if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port PCWr, input, 1, PC write enable from hazard detection (0 = stall PC).
REQ-004 SHALL have port IFIDWr, input, 1, IF/ID write enable from hazard detection (0 = hold IF/ID).
REQ-005 SHALL have port hazCtrl, input, 1, bubble request (1 = insert nop into ID/EX).
REQ-006 SHALL have port branchTaken, input, 1, branch resolved taken in ID stage.
REQ-007 SHALL have port branchTarget, input, 32, branch destination address.
REQ-008 SHALL have port instrIn, input, 32, instruction memory read data for address pc.
REQ-009 SHALL have port ctrlIn, input, 9, decoded control bundle for the instruction in ID.
REQ-010 SHALL have port pc, output, 32, current fetch address.
REQ-011 SHALL have port IFIDInstr, output, 32, registered instruction in ID.
REQ-012 SHALL have port IFIDPCPlus4, output, 32, registered pc+4 of that instruction.
REQ-013 SHALL have port IFIDValid, output, 1, IF/ID holds a real instruction.
REQ-014 SHALL have port IDEXCtrl, output, 9, registered control bundle entering EX.
REQ-015 SHALL have port IDEXValid, output, 1, ID/EX holds a real instruction.
REQ-016 SHALL have port stallCnt, output, 16, bubble cycle counter.
REQ-017 SHALL have port flushCnt, output, 16, IF/ID flush counter.

Function
REQ-018 SHALL, when rst=0 and branchTaken=1 and hazCtrl=0, load pc with {branchTarget[31:2],2'b00} regardless of PCWr.
REQ-019 SHALL otherwise load pc with pc+4 (mod 2^32, wrapping 0xFFFFFFFC -> 0) when PCWr=1, else hold pc.
REQ-020 SHALL keep pc[1:0]=0 at all times.
REQ-021 SHALL, on a qualified branch (branchTaken=1, hazCtrl=0), flush IF/ID: IFIDInstr=0, IFIDPCPlus4=0, IFIDValid=0, priority over IFIDWr.
REQ-022 SHALL otherwise, when IFIDWr=1, capture IFIDInstr=instrIn, IFIDPCPlus4=pc+4, IFIDValid=1; when IFIDWr=0, hold all IF/ID fields.
REQ-023 SHALL, when hazCtrl=1, load IDEXCtrl=0 and IDEXValid=0 (bubble); else IDEXCtrl=ctrlIn, IDEXValid=IFIDValid.
REQ-024 SHALL ignore branchTaken in any cycle with hazCtrl=1 (branch operands not yet available); branch is re-evaluated next cycle.
REQ-025 SHALL honor PCWr and IFIDWr independently when they disagree; no cross-checking.
REQ-026 SHALL have one-cycle latency on every registered output; no combinational input-to-output path.

Reset
REQ-027 SHALL, on rising clk with rst=1, set pc=0, IFIDInstr=0, IFIDPCPlus4=0, IFIDValid=0, IDEXCtrl=0, IDEXValid=0, stallCnt=0, flushCnt=0.
REQ-028 SHALL give rst priority over every other input, including mid-stall and mid-flush; first fetch after reset release is address 0.

Configuration
REQ-029 SHALL, with macro STALL_COUNT_EN defined, increment stallCnt on each cycle with hazCtrl=1 and flushCnt on each qualified branch, both saturating at 0xFFFF.
REQ-030 SHALL, without STALL_COUNT_EN, keep stallCnt and flushCnt ports present and constant 0, with no counter registers.

Verification
REQ-031 SHALL cover: rst=1 two cycles, then PCWr=IFIDWr=1 three cycles -> pc 0,4,8,12; IFIDPCPlus4 lags by one cycle; IFIDValid=1 from second cycle.
REQ-032 SHALL cover: load-use stall, PCWr=0, IFIDWr=0, hazCtrl=1 one cycle at pc=8 -> pc holds 8, IFIDInstr unchanged, IDEXCtrl=0, IDEXValid=0, stallCnt=1 (macro on).
REQ-033 SHALL cover: branchTaken=1, branchTarget=0x00000103, hazCtrl=0 -> pc=0x00000100, IFIDValid=0, IFIDInstr=0, flushCnt=1.
REQ-034 SHALL cover: branchTaken=1 with hazCtrl=1 -> pc holds, no flush; next cycle branchTaken=1, hazCtrl=0 -> pc=target.
REQ-035 SHALL cover: pc=0xFFFFFFFC, PCWr=1 -> pc=0; rst=1 asserted during stall -> all outputs 0 next edge; 70000 hazCtrl cycles -> stallCnt=0xFFFF.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID stage: PC register, IF/ID pipeline register and ID/EX control register.
// Latency: one cycle on every output; no combinational input-to-output path.
// Stalls come from PCWr/IFIDWr/hazCtrl. Optional counters are enabled by STALL_COUNT_EN.
module if_id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        IFIDWr,
  input  logic        hazCtrl,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic [31:0] instrIn,
  input  logic [8:0]  ctrlIn,
  output logic [31:0] pc,
  output logic [31:0] IFIDInstr,
  output logic [31:0] IFIDPCPlus4,
  output logic        IFIDValid,
  output logic [8:0]  IDEXCtrl,
  output logic        IDEXValid,
  output logic [15:0] stallCnt,
  output logic [15:0] flushCnt
);

  // A branch only counts when its operands are ready, i.e. no bubble this cycle.
  logic        branch_qual;
  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;

  assign branch_qual = branchTaken & ~hazCtrl;
  assign pc_plus4    = pc + 32'd4;
  // Masking keeps the fetch address word aligned even for a misaligned target.
  assign branch_pc   = branchTarget & 32'hFFFF_FFFC;

  // PC register: a qualified branch wins over PCWr; otherwise advance or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 32'd0;
    end else if (branch_qual) begin
      pc <= branch_pc;
    end else if (PCWr) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: flush on a qualified branch, else capture or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      IFIDInstr   <= 32'd0;
      IFIDPCPlus4 <= 32'd0;
      IFIDValid   <= 1'b0;
    end else if (branch_qual) begin
      IFIDInstr   <= 32'd0;
      IFIDPCPlus4 <= 32'd0;
      IFIDValid   <= 1'b0;
    end else if (IFIDWr) begin
      IFIDInstr   <= instrIn;
      IFIDPCPlus4 <= pc_plus4;
      IFIDValid   <= 1'b1;
    end
  end

  // ID/EX control register: a bubble zeroes the control bundle and validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      IDEXCtrl  <= 9'd0;
      IDEXValid <= 1'b0;
    end else if (hazCtrl) begin
      IDEXCtrl  <= 9'd0;
      IDEXValid <= 1'b0;
    end else begin
      IDEXCtrl  <= ctrlIn;
      IDEXValid <= IFIDValid;
    end
  end

`ifdef STALL_COUNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  // Saturating event counters for bubble cycles and branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (hazCtrl && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (branch_qual && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

  assign stallCnt = stall_count;
  assign flushCnt = flush_count;
`else
  // Counters compiled out: ports stay present and read as zero.
  assign stallCnt = 16'd0;
  assign flushCnt = 16'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, hand sequences,
// randomized traffic against a behavioural model, and counter saturation.
module tb_if_id_stage;

`ifdef STALL_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, PCWr, IFIDWr, hazCtrl, branchTaken;
  logic [31:0] branchTarget, instrIn;
  logic [8:0]  ctrlIn;
  logic [31:0] pc, IFIDInstr, IFIDPCPlus4;
  logic        IFIDValid, IDEXValid;
  logic [8:0]  IDEXCtrl;
  logic [15:0] stallCnt, flushCnt;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_idv;
  logic [8:0]  m_ctrl;
  int          m_stall, m_flush;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst(rst), .PCWr(PCWr), .IFIDWr(IFIDWr), .hazCtrl(hazCtrl),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .instrIn(instrIn),
    .ctrlIn(ctrlIn), .pc(pc), .IFIDInstr(IFIDInstr), .IFIDPCPlus4(IFIDPCPlus4),
    .IFIDValid(IFIDValid), .IDEXCtrl(IDEXCtrl), .IDEXValid(IDEXValid),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  typedef struct {
    logic        rst, pcwr, ifidwr, haz, br;
    logic [31:0] tgt, instr;
    logic [8:0]  ctrl;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid;
    logic [8:0]  e_ctrl;
    logic        e_idv;
    logic [15:0] e_stall, e_flush;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [15:0] cn(input int n);
    return (CNT_ON != 0) ? n[15:0] : 16'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: next state derived directly from the stage's rules.
  task automatic model_update();
    bit          qual;
    logic        old_valid;
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_ctrl = 0; m_idv = 0;
      m_stall = 0; m_flush = 0;
      return;
    end
    qual = branchTaken && !hazCtrl;
    old_valid = m_valid;
    if (qual) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (IFIDWr) begin
      m_instr = instrIn; m_pc4 = m_pc + 32'd4; m_valid = 1;
    end
    if (qual)      m_pc = (branchTarget >> 2) << 2;
    else if (PCWr) m_pc = m_pc + 32'd4;
    m_ctrl = hazCtrl ? 9'd0 : ctrlIn;
    m_idv  = hazCtrl ? 1'b0 : old_valid;
    if (CNT_ON != 0) begin
      if (hazCtrl && m_stall < 65535) m_stall++;
      if (qual && m_flush < 65535) m_flush++;
    end
  endtask

  task automatic step(input logic r, input logic pw, input logic iw, input logic hz,
                      input logic b, input logic [31:0] t, input logic [31:0] ins,
                      input logic [8:0] c);
    rst = r; PCWr = pw; IFIDWr = iw; hazCtrl = hz; branchTaken = b;
    branchTarget = t; instrIn = ins; ctrlIn = c;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".IFIDInstr"}, IFIDInstr, m_instr);
    chk({tag, ".IFIDPCPlus4"}, IFIDPCPlus4, m_pc4);
    chk({tag, ".IFIDValid"}, 32'(IFIDValid), 32'(m_valid));
    chk({tag, ".IDEXCtrl"}, 32'(IDEXCtrl), 32'(m_ctrl));
    chk({tag, ".IDEXValid"}, 32'(IDEXValid), 32'(m_idv));
    chk({tag, ".stallCnt"}, 32'(stallCnt), 32'(m_stall));
    chk({tag, ".flushCnt"}, 32'(flushCnt), 32'(m_flush));
  endtask

  initial begin
    rst = 1; PCWr = 0; IFIDWr = 0; hazCtrl = 0; branchTaken = 0;
    branchTarget = 0; instrIn = 0; ctrlIn = 0;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_ctrl = 0; m_idv = 0;
    m_stall = 0; m_flush = 0;

    //        rst  pcwr ifidwr haz  br    tgt            instr          ctrl     e_pc           e_instr        e_pc4          e_v   e_ctrl   e_idv stall   flush
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0,         9'h000, 32'h0,         32'h0,         32'h0,         1'b0, 9'h000, 1'b0, cn(0), cn(0)};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0,         9'h000, 32'h0,         32'h0,         32'h0,         1'b0, 9'h000, 1'b0, cn(0), cn(0)};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,         32'h000000A0,  9'h011, 32'h4,         32'h000000A0,  32'h4,         1'b1, 9'h011, 1'b0, cn(0), cn(0)};
    tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,         32'h000000A1,  9'h022, 32'h8,         32'h000000A1,  32'h8,         1'b1, 9'h022, 1'b1, cn(0), cn(0)};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,         32'h000000A2,  9'h1FF, 32'h8,         32'h000000A1,  32'h8,         1'b1, 9'h000, 1'b0, cn(1), cn(0)};
    tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,         32'h000000A2,  9'h033, 32'hC,         32'h000000A2,  32'hC,         1'b1, 9'h033, 1'b1, cn(1), cn(0)};
    tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 32'h00000103,  32'h000000A3,  9'h044, 32'h100,       32'h0,         32'h0,         1'b0, 9'h044, 1'b1, cn(1), cn(1)};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 32'h00000200,  32'h000000B0,  9'h055, 32'h100,       32'h0,         32'h0,         1'b0, 9'h000, 1'b0, cn(2), cn(1)};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'h00000200,  32'h000000B1,  9'h066, 32'h200,       32'h0,         32'h0,         1'b0, 9'h066, 1'b0, cn(2), cn(2)};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0,         32'h000000B2,  9'h077, 32'h204,       32'h0,         32'h0,         1'b0, 9'h077, 1'b0, cn(2), cn(2)};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0,         32'h000000B3,  9'h088, 32'h204,       32'h000000B3,  32'h208,       1'b1, 9'h088, 1'b0, cn(2), cn(2)};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,         32'h000000B4,  9'h0AA, 32'h204,       32'h000000B3,  32'h208,       1'b1, 9'h000, 1'b0, cn(3), cn(2)};
    tbl[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 32'h00000300,  32'h000000B5,  9'h0BB, 32'h0,         32'h0,         32'h0,         1'b0, 9'h000, 1'b0, cn(0), cn(0)};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,         32'h000000C0,  9'h099, 32'h4,         32'h000000C0,  32'h4,         1'b1, 9'h099, 1'b0, cn(0), cn(0)};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].pcwr, tbl[i].ifidwr, tbl[i].haz, tbl[i].br,
           tbl[i].tgt, tbl[i].instr, tbl[i].ctrl);
      chk($sformatf("vec%0d.pc", i), pc, tbl[i].e_pc);
      chk($sformatf("vec%0d.IFIDInstr", i), IFIDInstr, tbl[i].e_instr);
      chk($sformatf("vec%0d.IFIDPCPlus4", i), IFIDPCPlus4, tbl[i].e_pc4);
      chk($sformatf("vec%0d.IFIDValid", i), 32'(IFIDValid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.IDEXCtrl", i), 32'(IDEXCtrl), 32'(tbl[i].e_ctrl));
      chk($sformatf("vec%0d.IDEXValid", i), 32'(IDEXValid), 32'(tbl[i].e_idv));
      chk($sformatf("vec%0d.stallCnt", i), 32'(stallCnt), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d.flushCnt", i), 32'(flushCnt), 32'(tbl[i].e_flush));
    end

    // PC wrap: branch to a misaligned top address, then advance past 2^32.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 9'h0);
    chk("wrap.pc_top", pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0D00, 9'h0);
    chk("wrap.pc_zero", pc, 32'h0);
    chk("wrap.IFIDPCPlus4", IFIDPCPlus4, 32'h0);
    chk("wrap.IFIDInstr", IFIDInstr, 32'h0000_0D00);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
           ($urandom_range(3) == 0), ($urandom_range(7) == 0), $urandom, $urandom,
           9'($urandom));
      check_model("rand");
    end

    // Stall counter saturation after a long bubble run.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 9'h0);
    for (int i = 0; i < 70000; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 9'h1FF);
    end
    chk("sat.stallCnt", 32'(stallCnt), 32'(cn(65535)));
    chk("sat.flushCnt", 32'(flushCnt), 32'h0);
    chk("sat.pc", pc, 32'h0);
    check_model("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
